// File: rtl/sprite_pkg.sv
// Shared types for the sprite line scheduler: attribute word layout, table/slot
// records and the scan FSM state encoding.
package sprite_pkg;

  localparam int ATTR_COL_LSB   = 0;
  localparam int ATTR_COL_W     = 10;
  localparam int ATTR_ROW_LSB   = 10;
  localparam int ATTR_ROW_W     = 10;
  localparam int ATTR_COLOR_LSB = 20;
  localparam int ATTR_COLOR_W   = 4;
  localparam int ATTR_EN_BIT    = 31;

  typedef struct packed {
    logic                    en;
    logic [ATTR_COLOR_W-1:0] color;
    logic [ATTR_ROW_W-1:0]   row;
    logic [ATTR_COL_W-1:0]   col;
  } sprite_attr_t;

  typedef struct packed {
    logic                    valid;
    logic [ATTR_COL_W-1:0]   col;
    logic [ATTR_COLOR_W-1:0] color;
  } slot_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} sched_state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// Vertical hit test of one sprite against a display row, plus the sprite line
// index to fetch. Compared at 11 bits so sprites near the bottom clip, not wrap.
module sprite_hit_check
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE = 16
) (
  input  logic                        en,
  input  logic [ATTR_ROW_W-1:0]       row,
  input  logic [ATTR_ROW_W-1:0]       next_row,
  output logic                        hit,
  output logic [$clog2(SPR_SIZE)-1:0] line
);

  localparam int LW = $clog2(SPR_SIZE);

  logic [ATTR_ROW_W:0] row_lo;
  logic [ATTR_ROW_W:0] row_hi;
  logic [ATTR_ROW_W:0] probe;

  always_comb begin
    row_lo = {1'b0, row};
    row_hi = row_lo + (ATTR_ROW_W+1)'(SPR_SIZE);
    probe  = {1'b0, next_row};
    hit    = en && (probe >= row_lo) && (probe < row_hi);
    line   = LW'(next_row - row);
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: double-buffered attribute table, hblank scan
// in index order, and registered slot outputs for the overlay mux.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPR   = 8,
  parameter int NUM_SLOTS = 4,
  parameter int SPR_SIZE  = 16
) (
  input  logic                                 vga_clk,
  input  logic                                 vga_rst,
  input  logic                                 attr_we,
  input  logic [$clog2(NUM_SPR)-1:0]           attr_addr,
  input  logic [31:0]                          attr_wdata,
  input  logic                                 frame_start,
  input  logic                                 line_start,
  input  logic [9:0]                           next_row,
  output logic [NUM_SLOTS-1:0]                 slot_valid,
  output logic [NUM_SLOTS*10-1:0]              slot_col,
  output logic [NUM_SLOTS*$clog2(SPR_SIZE)-1:0] slot_line,
  output logic [NUM_SLOTS*4-1:0]               slot_color,
  output logic                                 sched_busy,
  output logic                                 sched_done,
  output logic                                 line_overflow
);

  localparam int IW = $clog2(NUM_SPR);
  localparam int LW = $clog2(SPR_SIZE);
  localparam int CW = $clog2(NUM_SLOTS+1);
  localparam int SW = $clog2(NUM_SLOTS);

  sprite_attr_t shadow [NUM_SPR];
  sprite_attr_t active [NUM_SPR];

  sched_state_t   state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic [9:0]     cur_row;
  logic           commit_pend;

  slot_t          build_slot [NUM_SLOTS];
  logic [LW-1:0]  build_line [NUM_SLOTS];
  slot_t          out_slot   [NUM_SLOTS];
  logic [LW-1:0]  out_line   [NUM_SLOTS];

  sprite_attr_t   wr_attr;
  sprite_attr_t   cur_attr;
  logic           hit;
  logic [LW-1:0]  hit_line;
  logic           do_commit;
  logic           unused_wdata;

  always_comb begin
    wr_attr       = '0;
    wr_attr.col   = attr_wdata[ATTR_COL_LSB +: ATTR_COL_W];
    wr_attr.row   = attr_wdata[ATTR_ROW_LSB +: ATTR_ROW_W];
    wr_attr.color = attr_wdata[ATTR_COLOR_LSB +: ATTR_COLOR_W];
    wr_attr.en    = attr_wdata[ATTR_EN_BIT];
  end
  assign unused_wdata = ^attr_wdata[30:24];

  assign cur_attr = active[idx];

  sprite_hit_check #(
    .SPR_SIZE(SPR_SIZE)
  ) u_hit (
    .en      (cur_attr.en),
    .row     (cur_attr.row),
    .next_row(cur_row),
    .hit     (hit),
    .line    (hit_line)
  );

  // A commit deferred during a scan lands on the DONE->IDLE edge; an abort
  // in DONE skips that edge and keeps the commit pending.
  always_comb begin
    do_commit = 1'b0;
    if (state == S_IDLE && frame_start)
      do_commit = 1'b1;
    else if (state == S_DONE && !line_start && (commit_pend || frame_start))
      do_commit = 1'b1;
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      cur_row       <= '0;
      commit_pend   <= 1'b0;
      sched_busy    <= 1'b0;
      sched_done    <= 1'b0;
      line_overflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        build_slot[i] <= '0;
        build_line[i] <= '0;
        out_slot[i]   <= '0;
        out_line[i]   <= '0;
      end
    end else begin
      sched_done <= 1'b0;
      if (attr_we)
        shadow[attr_addr] <= wr_attr;
      if (do_commit)
        for (int unsigned i = 0; i < NUM_SPR; i++)
          active[i] <= shadow[i];
      if (frame_start)
        line_overflow <= 1'b0;

      if (line_start) begin
        state      <= S_SCAN;
        idx        <= '0;
        cnt        <= '0;
        cur_row    <= next_row;
        sched_busy <= 1'b1;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          build_slot[i] <= '0;
          build_line[i] <= '0;
        end
        if (state != S_IDLE && frame_start)
          commit_pend <= 1'b1;
      end else begin
        case (state)
          S_SCAN: begin
            if (frame_start)
              commit_pend <= 1'b1;
            if (hit) begin
              if (cnt == CW'(NUM_SLOTS)) begin
                line_overflow <= 1'b1;
              end else begin
                build_slot[cnt[SW-1:0]].valid <= 1'b1;
                build_slot[cnt[SW-1:0]].col   <= cur_attr.col;
                build_slot[cnt[SW-1:0]].color <= cur_attr.color;
                build_line[cnt[SW-1:0]]       <= hit_line;
                cnt                           <= cnt + CW'(1);
              end
            end
            if (idx == IW'(NUM_SPR-1))
              state <= S_DONE;
            else
              idx <= idx + IW'(1);
          end
          S_DONE: begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              out_slot[i] <= build_slot[i];
              out_line[i] <= build_line[i];
            end
            sched_done  <= 1'b1;
            sched_busy  <= 1'b0;
            commit_pend <= 1'b0;
            state       <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    slot_valid = '0;
    slot_col   = '0;
    slot_line  = '0;
    slot_color = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_valid[i]         = out_slot[i].valid;
      slot_col[i*10 +: 10]  = out_slot[i].col;
      slot_line[i*LW +: LW] = out_line[i];
      slot_color[i*4 +: 4]  = out_slot[i].color;
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with hand-computed slot contents.
`timescale 1ns/1ps
module tb_sprite_line_scheduler;

  logic        vga_clk = 1'b0;
  logic        vga_rst;
  logic        attr_we;
  logic [2:0]  attr_addr;
  logic [31:0] attr_wdata;
  logic        frame_start;
  logic        line_start;
  logic [9:0]  next_row;
  logic [3:0]  slot_valid;
  logic [39:0] slot_col;
  logic [15:0] slot_line;
  logic [15:0] slot_color;
  logic        sched_busy;
  logic        sched_done;
  logic        line_overflow;

  int tests  = 0;
  int failed = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_line_scheduler #(
    .NUM_SPR  (8),
    .NUM_SLOTS(4),
    .SPR_SIZE (16)
  ) dut (
    .vga_clk      (vga_clk),
    .vga_rst      (vga_rst),
    .attr_we      (attr_we),
    .attr_addr    (attr_addr),
    .attr_wdata   (attr_wdata),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .next_row     (next_row),
    .slot_valid   (slot_valid),
    .slot_col     (slot_col),
    .slot_line    (slot_line),
    .slot_color   (slot_color),
    .sched_busy   (sched_busy),
    .sched_done   (sched_done),
    .line_overflow(line_overflow)
  );

  task automatic tick;
    @(posedge vga_clk); #1;
  endtask

  task automatic write_attr(input int idx, input int row, input int col,
                            input int color, input logic en);
    attr_we    = 1'b1;
    attr_addr  = 3'(idx);
    attr_wdata = {en, 7'd0, 4'(color), 10'(row), 10'(col)};
    tick();
    attr_we    = 1'b0;
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drives line_start (sampled at edge 0); cyc = edge index where done shows, -1 on timeout.
  task automatic run_line(input int row, output int cyc);
    line_start = 1'b1;
    next_row   = 10'(row);
    tick();
    line_start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sched_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int cyc;
    vga_rst = 1'b1;
    repeat (3) tick();
    vga_rst = 1'b0;
    tick();
    tests++;
    if ({slot_valid, slot_col, slot_line, slot_color, sched_busy, sched_done, line_overflow} !== '0) begin
      failed++;
      $display("FAIL reset_outputs got v=%b col=%h line=%h color=%h busy=%b done=%b ovf=%b want all zero",
               slot_valid, slot_col, slot_line, slot_color, sched_busy, sched_done, line_overflow);
    end
    run_line(0, cyc);
    tests++;
    if (cyc !== 9) begin failed++; $display("FAIL reset_scan_latency got %0d want 9", cyc); end
    tests++;
    if (slot_valid !== 4'b0000) begin failed++; $display("FAIL reset_scan_valid got %b want 0000", slot_valid); end
  endtask

  task automatic test_shadow;
    int cyc;
    write_attr(2, 100, 50, 3, 1'b1);
    run_line(100, cyc);
    tests++;
    if (slot_valid !== 4'b0000) begin failed++; $display("FAIL shadow_precommit got %b want 0000", slot_valid); end
    pulse_frame();
    run_line(100, cyc);
    tests++;
    if (slot_valid !== 4'b0001 || slot_col[9:0] !== 10'd50 || slot_line[3:0] !== 4'd0 || slot_color[3:0] !== 4'd3) begin
      failed++;
      $display("FAIL shadow_row100 got v=%b col=%0d line=%0d color=%0d want 0001/50/0/3",
               slot_valid, slot_col[9:0], slot_line[3:0], slot_color[3:0]);
    end
    run_line(115, cyc);
    tests++;
    if (slot_valid !== 4'b0001 || slot_line[3:0] !== 4'd15) begin
      failed++;
      $display("FAIL shadow_row115 got v=%b line=%0d want 0001/15", slot_valid, slot_line[3:0]);
    end
    run_line(116, cyc);
    tests++;
    if (slot_valid !== 4'b0000) begin failed++; $display("FAIL shadow_row116 got %b want 0000", slot_valid); end
  endtask

  task automatic test_overflow;
    int cyc;
    for (int i = 0; i < 6; i++) write_attr(i, 200, 10 * i, i, 1'b1);
    pulse_frame();
    tests++;
    if (line_overflow !== 1'b0) begin failed++; $display("FAIL ovf_initial got %b want 0", line_overflow); end
    run_line(205, cyc);
    tests++;
    if (slot_valid !== 4'b1111 || slot_col !== {10'd30, 10'd20, 10'd10, 10'd0} ||
        slot_line !== 16'h5555 || slot_color !== 16'h3210) begin
      failed++;
      $display("FAIL ovf_slots got v=%b col=%h line=%h color=%h want 1111/%h/5555/3210",
               slot_valid, slot_col, slot_line, slot_color, {10'd30, 10'd20, 10'd10, 10'd0});
    end
    tests++;
    if (line_overflow !== 1'b1) begin failed++; $display("FAIL ovf_set got %b want 1", line_overflow); end
    run_line(0, cyc);
    tests++;
    if (line_overflow !== 1'b1 || slot_valid !== 4'b0000) begin
      failed++;
      $display("FAIL ovf_sticky got ovf=%b v=%b want 1/0000", line_overflow, slot_valid);
    end
    pulse_frame();
    tests++;
    if (line_overflow !== 1'b0) begin failed++; $display("FAIL ovf_clear got %b want 0", line_overflow); end
  endtask

  task automatic test_commit_midscan;
    int cyc;
    write_attr(0, 300, 77, 9, 1'b1);
    line_start = 1'b1;
    next_row   = 10'd205;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cyc = -1;
    for (int i = 4; i <= 40; i++) begin
      tick();
      if (sched_done) begin cyc = i; break; end
    end
    tests++;
    if (cyc !== 9 || slot_valid !== 4'b1111 || slot_col !== {10'd30, 10'd20, 10'd10, 10'd0}) begin
      failed++;
      $display("FAIL commit_midscan_old got cyc=%0d v=%b col=%h want 9/1111/%h",
               cyc, slot_valid, slot_col, {10'd30, 10'd20, 10'd10, 10'd0});
    end
    run_line(205, cyc);
    tests++;
    if (slot_valid !== 4'b1111 || slot_col !== {10'd40, 10'd30, 10'd20, 10'd10} || slot_color !== 16'h4321) begin
      failed++;
      $display("FAIL commit_midscan_new got v=%b col=%h color=%h want 1111/%h/4321",
               slot_valid, slot_col, slot_color, {10'd40, 10'd30, 10'd20, 10'd10});
    end
    run_line(300, cyc);
    tests++;
    if (slot_valid !== 4'b0001 || slot_col[9:0] !== 10'd77 || slot_color[3:0] !== 4'd9) begin
      failed++;
      $display("FAIL commit_midscan_row300 got v=%b col=%0d color=%0d want 0001/77/9",
               slot_valid, slot_col[9:0], slot_color[3:0]);
    end
  endtask

  task automatic test_back_to_back;
    int ndone;
    int first;
    line_start = 1'b1;
    next_row   = 10'd300;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    line_start = 1'b1;
    next_row   = 10'd205;
    tests++;
    if (sched_busy !== 1'b1 || slot_valid !== 4'b0001) begin
      failed++;
      $display("FAIL abort_hold got busy=%b v=%b want 1/0001", sched_busy, slot_valid);
    end
    tick();
    line_start = 1'b0;
    ndone = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sched_done) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (ndone !== 1 || first !== 9) begin
      failed++;
      $display("FAIL abort_done got count=%0d at=%0d want 1 at 9", ndone, first);
    end
    tests++;
    if (slot_valid !== 4'b1111 || slot_col !== {10'd40, 10'd30, 10'd20, 10'd10}) begin
      failed++;
      $display("FAIL abort_slots got v=%b col=%h want 1111/%h", slot_valid, slot_col, {10'd40, 10'd30, 10'd20, 10'd10});
    end
  endtask

  task automatic test_bottom_clip;
    int cyc;
    write_attr(7, 1020, 600, 15, 1'b1);
    pulse_frame();
    run_line(1023, cyc);
    tests++;
    if (slot_valid !== 4'b0001 || slot_line[3:0] !== 4'd3 || slot_col[9:0] !== 10'd600 || slot_color[3:0] !== 4'd15) begin
      failed++;
      $display("FAIL clip_row1023 got v=%b line=%0d col=%0d color=%0d want 0001/3/600/15",
               slot_valid, slot_line[3:0], slot_col[9:0], slot_color[3:0]);
    end
    run_line(0, cyc);
    tests++;
    if (slot_valid !== 4'b0000) begin failed++; $display("FAIL clip_row0 got %b want 0000", slot_valid); end
    run_line(1019, cyc);
    tests++;
    if (slot_valid !== 4'b0000) begin failed++; $display("FAIL clip_row1019 got %b want 0000", slot_valid); end
  endtask

  task automatic test_same_cycle;
    int cyc;
    write_attr(7, 1020, 601, 15, 1'b1);
    frame_start = 1'b1;
    line_start  = 1'b1;
    next_row    = 10'd1023;
    tick();
    frame_start = 1'b0;
    line_start  = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sched_done) begin cyc = i; break; end
    end
    tests++;
    if (cyc !== 9 || slot_col[9:0] !== 10'd601) begin
      failed++;
      $display("FAIL frame_line_same got cyc=%0d col=%0d want 9/601", cyc, slot_col[9:0]);
    end
    frame_start = 1'b1;
    attr_we     = 1'b1;
    attr_addr   = 3'd7;
    attr_wdata  = {1'b1, 7'd0, 4'd15, 10'd1020, 10'd602};
    tick();
    frame_start = 1'b0;
    attr_we     = 1'b0;
    run_line(1023, cyc);
    tests++;
    if (slot_col[9:0] !== 10'd601) begin failed++; $display("FAIL write_at_commit_old got %0d want 601", slot_col[9:0]); end
    pulse_frame();
    run_line(1023, cyc);
    tests++;
    if (slot_col[9:0] !== 10'd602) begin failed++; $display("FAIL write_at_commit_new got %0d want 602", slot_col[9:0]); end
  endtask

  task automatic test_reset_midscan;
    int ndone;
    int cyc;
    line_start = 1'b1;
    next_row   = 10'd1023;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    vga_rst = 1'b1;
    tick();
    vga_rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (sched_done) ndone++;
      tick();
    end
    tests++;
    if (ndone !== 0 || sched_busy !== 1'b0 || slot_valid !== 4'b0000) begin
      failed++;
      $display("FAIL reset_midscan got done=%0d busy=%b v=%b want 0/0/0000", ndone, sched_busy, slot_valid);
    end
    pulse_frame();
    run_line(1023, cyc);
    tests++;
    if (cyc !== 9 || slot_valid !== 4'b0000) begin
      failed++;
      $display("FAIL reset_tables_cleared got cyc=%0d v=%b want 9/0000", cyc, slot_valid);
    end
  endtask

  initial begin
    vga_rst     = 1'b1;
    attr_we     = 1'b0;
    attr_addr   = '0;
    attr_wdata  = '0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    next_row    = '0;
    test_reset();
    test_shadow();
    test_overflow();
    test_commit_midscan();
    test_back_to_back();
    test_bottom_clip();
    test_same_cycle();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
